// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and types for the CPU datapath
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one register file read port: zero check and optional write-first bypass
module rf_read_port #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] stored,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);
    import cpu_pkg::*;

    logic is_zero;
    logic hit;

    assign is_zero = (idx == ADDR_W'(REG_ZERO));
    assign hit     = BYPASS && wr_en && (wr_addr != ADDR_W'(REG_ZERO)) && (wr_addr == idx);

    // Reset gates the bypass too, so nothing leaks through while storage is held clear.
    always_comb begin
        data = '0;
        if (reset && !is_zero) begin
            data = hit ? wr_data : stored;
        end
    end
endmodule

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - architectural register file with WB->ID bypass and committed-write counter
module wb_register_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] WB_write_data,
    input  logic [ADDR_W-1:0] WB_Rd,
    input  logic              WB_RegWrite,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    output logic [DATA_W-1:0] ID_Rs_data,
    output logic [DATA_W-1:0] ID_Rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wb_count
);
    import cpu_pkg::*;

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;

    assign commit = WB_RegWrite && (WB_Rd != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[WB_Rd] <= WB_write_data;
            wb_count    <= wb_count + CNT_W'(1);
        end
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_port_a (
        .reset   (reset),
        .idx     (ID_Rs),
        .stored  (regs[ID_Rs]),
        .wr_en   (WB_RegWrite),
        .wr_addr (WB_Rd),
        .wr_data (WB_write_data),
        .data    (ID_Rs_data)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_port_b (
        .reset   (reset),
        .idx     (ID_Rt),
        .stored  (regs[ID_Rt]),
        .wr_en   (WB_RegWrite),
        .wr_addr (WB_Rd),
        .wr_data (WB_write_data),
        .data    (ID_Rt_data)
    );

    // Debug view shows stored contents only, so the pre-write value is visible during a write.
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_port_dbg (
        .reset   (reset),
        .idx     (dbg_addr),
        .stored  (regs[dbg_addr]),
        .wr_en   (WB_RegWrite),
        .wr_addr (WB_Rd),
        .wr_data (WB_write_data),
        .data    (dbg_data)
    );
endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - directed self-checking bench for wb_register_file
module tb_wb_register_file;
    import cpu_pkg::*;

    logic     clk;
    logic     reset;
    word_t    WB_write_data;
    reg_idx_t WB_Rd;
    logic     WB_RegWrite;
    reg_idx_t ID_Rs;
    reg_idx_t ID_Rt;
    word_t    ID_Rs_data;
    word_t    ID_Rt_data;
    reg_idx_t dbg_addr;
    word_t    dbg_data;
    logic [31:0] wb_count;

    word_t    w_rs_data;
    word_t    w_rt_data;
    word_t    w_dbg_data;
    logic [3:0] w_count;

    int total;
    int passed;

    wb_register_file dut (
        .clk           (clk),
        .reset         (reset),
        .WB_write_data (WB_write_data),
        .WB_Rd         (WB_Rd),
        .WB_RegWrite   (WB_RegWrite),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_Rs_data    (ID_Rs_data),
        .ID_Rt_data    (ID_Rt_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .wb_count      (wb_count)
    );

    wb_register_file #(.CNT_W(4)) dut_w (
        .clk           (clk),
        .reset         (reset),
        .WB_write_data (WB_write_data),
        .WB_Rd         (WB_Rd),
        .WB_RegWrite   (WB_RegWrite),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_Rs_data    (w_rs_data),
        .ID_Rt_data    (w_rt_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (w_dbg_data),
        .wb_count      (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset         = 1'b0;
        WB_RegWrite   = 1'b1;
        WB_Rd         = 5'd4;
        WB_write_data = 32'h0000_0077;
        ID_Rs         = 5'd4;
        ID_Rt         = 5'd4;
        dbg_addr      = 5'd4;

        #3;
        check("reset_rs_gated", ID_Rs_data, 32'h0);
        check("reset_rt_gated", ID_Rt_data, 32'h0);
        check("reset_dbg", dbg_data, 32'h0);
        check("reset_count", wb_count, 32'h0);
        tick();
        tick();
        check("reset_write_lost", dbg_data, 32'h0);
        check("reset_count_held", wb_count, 32'h0);

        reset         = 1'b1;
        WB_Rd         = 5'd5;
        WB_write_data = 32'hDEAD_BEEF;
        ID_Rs         = 5'd5;
        #1;
        check("first_bypass", ID_Rs_data, 32'hDEAD_BEEF);
        tick();
        WB_Rd         = 5'd6;
        WB_write_data = 32'h0000_0066;
        #1;
        check("first_store", ID_Rs_data, 32'hDEAD_BEEF);
        check("first_count", wb_count, 32'd1);
        tick();
        check("second_count", wb_count, 32'd2);

        // Asynchronous reset mid-run with a write pending
        WB_Rd         = 5'd8;
        WB_write_data = 32'h0000_0088;
        ID_Rt         = 5'd8;
        dbg_addr      = 5'd6;
        reset         = 1'b0;
        #1;
        check("midrst_rs", ID_Rs_data, 32'h0);
        check("midrst_rt_bypass_gated", ID_Rt_data, 32'h0);
        check("midrst_dbg", dbg_data, 32'h0);
        check("midrst_count", wb_count, 32'h0);
        check("midrst_count_w", 32'(w_count), 32'h0);
        tick();
        reset         = 1'b1;
        WB_Rd         = 5'd5;
        WB_write_data = 32'hDEAD_BEEF;
        tick();
        WB_RegWrite = 1'b0;
        #1;
        check("rel_readback", ID_Rs_data, 32'hDEAD_BEEF);
        check("rel_lost_write", ID_Rt_data, 32'h0);
        check("rel_count", wb_count, 32'd1);

        WB_RegWrite   = 1'b1;
        WB_Rd         = 5'd0;
        WB_write_data = 32'h1234_5678;
        ID_Rs         = 5'd0;
        ID_Rt         = 5'd0;
        dbg_addr      = 5'd0;
        #1;
        check("zero_rs", ID_Rs_data, 32'h0);
        check("zero_rt", ID_Rt_data, 32'h0);
        tick();
        WB_RegWrite = 1'b0;
        #1;
        check("zero_dbg", dbg_data, 32'h0);
        check("zero_count", wb_count, 32'd1);

        WB_RegWrite   = 1'b1;
        WB_Rd         = 5'd7;
        WB_write_data = 32'hA5A5_A5A5;
        ID_Rs         = 5'd7;
        ID_Rt         = 5'd7;
        dbg_addr      = 5'd7;
        #1;
        check("bypass_rs", ID_Rs_data, 32'hA5A5_A5A5);
        check("bypass_rt", ID_Rt_data, 32'hA5A5_A5A5);
        check("bypass_dbg_old", dbg_data, 32'h0);
        tick();
        WB_RegWrite = 1'b0;
        #1;
        check("bypass_dbg_new", dbg_data, 32'hA5A5_A5A5);
        check("bypass_count", wb_count, 32'd2);

        WB_RegWrite   = 1'b1;
        WB_Rd         = 5'd9;
        WB_write_data = 32'hCAFE_F00D;
        ID_Rs         = 5'd9;
        ID_Rt         = 5'd7;
        #1;
        check("indep_rs", ID_Rs_data, 32'hCAFE_F00D);
        check("indep_rt", ID_Rt_data, 32'hA5A5_A5A5);
        tick();
        WB_RegWrite = 1'b0;
        #1;
        check("indep_count", wb_count, 32'd3);

        WB_RegWrite   = 1'b0;
        WB_Rd         = 5'd3;
        WB_write_data = 32'hFFFF_FFFF;
        ID_Rs         = 5'd3;
        dbg_addr      = 5'd3;
        #1;
        check("en_low_no_bypass", ID_Rs_data, 32'h0);
        tick();
        check("en_low_dbg", dbg_data, 32'h0);
        check("en_low_count", wb_count, 32'd3);

        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);

        for (int i = 1; i < 32; i++) begin
            WB_RegWrite   = 1'b1;
            WB_Rd         = 5'(i);
            WB_write_data = 32'(i);
            tick();
            if (i == 17) check("wrap_17_writes", 32'(w_count), 32'd1);
        end
        WB_RegWrite = 1'b0;
        #1;
        check("b2b_count", wb_count, 32'd31);
        check("b2b_count_w", 32'(w_count), 32'd15);

        for (int i = 1; i < 32; i++) begin
            dbg_addr = 5'(i);
            ID_Rs    = 5'(i);
            ID_Rt    = 5'(32 - i);
            #1;
            check("b2b_dbg", dbg_data, 32'(i));
            check("b2b_rs", ID_Rs_data, 32'(i));
            check("b2b_rt", ID_Rt_data, 32'(32 - i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
